n_accumulator: RTL and testbench

Sequential signed accumulator that sits directly downstream of the `n_adder` ripple-carry stage. It feeds back its own running sum and each incoming operand into an internal `n_adder` instance (`ci` = 0). It registers the result, sums a fixed-length frame of `LEN` operands, and presents the frame total on a valid/ready output port with a sticky signed-overflow flag. It converts the combinational adder into a streaming reduction stage.

---
 rtl/n_accumulator_if.sv | 22 ++
 rtl/n_accumulator.sv | 130 +++++++++++++
 tb/tb_n_accumulator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/n_accumulator_if.sv
// rtl/n_accumulator_if.sv - operand-in / frame-result-out handshake bundle for n_accumulator
interface n_accumulator_if #(
    parameter int N = 4
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_data;
    logic         m_ovf;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_ovf
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_ovf
    );
endinterface

// File: rtl/n_accumulator.sv
// rtl/n_accumulator.sv - LEN-operand signed frame accumulator built on a ripple-carry n_adder
// Optional saturation on signed overflow: define N_ACC_SAT_EN.
module n_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s
);
    logic [N-1:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i] = a[i] ^ b[i] ^ c[i];
        // The final carry out is never consumed, so the chain stops at the MSB.
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
endmodule

module n_accumulator #(
    parameter int N   = 4,
    parameter int LEN = 4
) (
    input  logic             clk,
    input  logic             rstn,
    n_accumulator_if.slave   bus
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          m_valid_q, m_valid_d;
    logic [N-1:0]  m_data_q, m_data_d;
    logic          m_ovf_q, m_ovf_d;

    logic [N-1:0]  sum;
    logic [N-1:0]  acc_next;
    logic          ovf_now;
    logic          beat;

    n_adder #(.N(N)) u_adder (
        .a  (acc_q),
        .b  (bus.s_data),
        .ci (1'b0),
        .s  (sum)
    );

    assign ovf_now = (acc_q[N-1] == bus.s_data[N-1]) && (sum[N-1] != acc_q[N-1]);

`ifdef N_ACC_SAT_EN
    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
    // Operand signs agree on overflow, so acc's sign tells the direction.
    assign acc_next = ovf_now ? (acc_q[N-1] ? SAT_MIN : SAT_MAX) : sum;
`else
    assign acc_next = sum;
`endif

    assign bus.s_ready = (state_q == ACC);
    assign beat        = bus.s_valid && bus.s_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ovf_d   = m_ovf_q;
        case (state_q)
            ACC: begin
                if (beat) begin
                    if (cnt_q == LAST) begin
                        m_data_d  = acc_next;
                        m_ovf_d   = ovf_q | ovf_now;
                        m_valid_d = 1'b1;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        acc_d = acc_next;
                        ovf_d = ovf_q | ovf_now;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ovf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ovf_q   <= m_ovf_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_ovf   = m_ovf_q;
endmodule

// File: tb/tb_n_accumulator.sv
// tb/tb_n_accumulator.sv - directed table-driven bench for n_accumulator (N=4, LEN=4)
module tb_n_accumulator;
    logic clk = 1'b0;
    logic rstn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    n_accumulator_if #(.N(4)) bus ();

    n_accumulator #(.N(4), .LEN(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic [15:0] ops;
        logic [3:0]  exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_op(input logic [3:0] v);
        int t;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = v;
        t = 0;
        while (!bus.s_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [15:0] ops);
        for (int i = 3; i >= 0; i--) send_op(ops[i*4 +: 4]);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic chk_result(input string name, input logic [3:0] d, input logic o);
        chk({name, "_m_valid"}, 32'(bus.m_valid), 1);
        chk({name, "_m_data"},  32'(bus.m_data),  32'(d));
        chk({name, "_m_ovf"},   32'(bus.m_ovf),   32'(o));
        chk({name, "_s_ready"}, 32'(bus.s_ready), 0);
    endtask

    initial begin
        int rec[$];

        vecs[0] = '{"basic",   {4'd1, 4'd2, 4'd3, 4'hF}, 4'd5, 1'b0};
        vecs[1] = '{"no_ovf",  {4'h8, 4'd7, 4'd0, 4'd0}, 4'hF, 1'b0};
`ifdef N_ACC_SAT_EN
        vecs[2] = '{"pos_ovf", {4'd7, 4'd1, 4'd0, 4'd0}, 4'd7, 1'b1};
        vecs[3] = '{"neg_ovf", {4'h8, 4'hF, 4'd0, 4'd0}, 4'h8, 1'b1};
        vecs[4] = '{"sticky",  {4'd5, 4'd5, 4'hD, 4'hD}, 4'd1, 1'b1};
`else
        vecs[2] = '{"pos_ovf", {4'd7, 4'd1, 4'd0, 4'd0}, 4'h8, 1'b1};
        vecs[3] = '{"neg_ovf", {4'h8, 4'hF, 4'd0, 4'd0}, 4'd7, 1'b1};
        vecs[4] = '{"sticky",  {4'd5, 4'd5, 4'hD, 4'hD}, 4'd4, 1'b1};
`endif

        rstn        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data",  32'(bus.m_data),  0);
        chk("rst_m_ovf",   32'(bus.m_ovf),   0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 32'(bus.s_ready), 1);

        for (int k = 0; k < 5; k++) begin
            send_frame(vecs[k].ops);
            chk_result(vecs[k].name, vecs[k].exp_data, vecs[k].exp_ovf);
            @(negedge clk);
            chk({vecs[k].name, "_after_valid"}, 32'(bus.m_valid), 0);
            chk({vecs[k].name, "_after_ready"}, 32'(bus.s_ready), 1);
        end

        // Backpressure: operand 7 offered during HOLD must be ignored.
        bus.m_ready = 1'b0;
        send_frame({4'd1, 4'd2, 4'd3, 4'hF});
        bus.s_valid = 1'b1;
        bus.s_data  = 4'd7;
        for (int c = 0; c < 4; c++) begin
            chk_result("bp", 4'd5, 1'b0);
            if (c < 3) @(negedge clk);
        end
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.m_valid), 0);
        chk("bp_release_ready", 32'(bus.s_ready), 1);
        send_frame({4'd1, 4'd1, 4'd1, 4'd1});
        chk_result("bp_next", 4'd4, 1'b0);
        @(negedge clk);

        // Streaming: three frames of ones, results every LEN+1 cycles.
        bus.s_valid = 1'b1;
        bus.s_data  = 4'd1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                rec.push_back(c);
                chk("stream_data", 32'(bus.m_data), 4);
                chk("stream_ovf",  32'(bus.m_ovf),  0);
            end
        end
        bus.s_valid = 1'b0;
        chk("stream_frames", 32'(rec.size()), 3);
        if (rec.size() == 3) begin
            chk("stream_latency", 32'(rec[0]), 4);
            chk("stream_gap1", 32'(rec[1] - rec[0]), 5);
            chk("stream_gap2", 32'(rec[2] - rec[1]), 5);
        end
        @(negedge clk);

        // Reset mid-frame discards the partial sum.
        send_op(4'd3);
        send_op(4'd3);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 0);
        chk("midrst_m_data",  32'(bus.m_data),  0);
        chk("midrst_m_ovf",   32'(bus.m_ovf),   0);
        @(negedge clk);
        rstn = 1'b1;
        send_frame({4'd1, 4'd1, 4'd1, 4'd1});
        chk_result("midrst_next", 4'd4, 1'b0);
        @(negedge clk);

        // Reset during HOLD drops the pending result asynchronously.
        bus.m_ready = 1'b0;
        send_frame({4'd7, 4'd1, 4'd0, 4'd0});
        chk("hold_pre_valid", 32'(bus.m_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("holdrst_m_valid", 32'(bus.m_valid), 0);
        chk("holdrst_m_data",  32'(bus.m_data),  0);
        chk("holdrst_m_ovf",   32'(bus.m_ovf),   0);
        chk("holdrst_s_ready", 32'(bus.s_ready), 1);
        @(negedge clk);
        rstn = 1'b1;
        bus.m_ready = 1'b1;
        send_frame({4'd2, 4'd2, 4'd2, 4'hF});
        chk_result("holdrst_next", 4'd5, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
